// File: rtl/gray_rx_decoder.sv
// Gray-code counter receiver: decodes each valid Gray word to binary, checks that the
// stream advances by +1, counts step errors and tracks lock on the counter stream.
`timescale 1ns/1ps
module gray_rx_decoder #(
  parameter int CBITS  = 18,
  parameter int LOCK_N = 4,
  parameter int ECBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CBITS-1:0]  gray_in,
  input  logic              gray_vld,
  output logic [CBITS-1:0]  bin_out,
  output logic              bin_vld,
  output logic              step_err,
  output logic              wrap_pulse,
  output logic              zero_seen,
  output logic              locked,
  output logic [ECBITS-1:0] err_cnt,
  output logic [1:0]        state_dbg,
  output logic [7:0]        run_dbg
);

  // Handshake: gray_vld is a one-cycle strobe, every strobed word is accepted (no ready);
  // bin_vld pulses exactly once per accepted word, two cycles later, with its flags.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [CBITS-1:0]  ALL_ONES = '1;
  localparam logic [ECBITS-1:0] EC_MAX   = '1;
  localparam logic [7:0]        LOCK_N8  = 8'(LOCK_N);

  logic [CBITS-1:0] g1;
  logic             v1;
  logic [CBITS-1:0] bin_c;
  logic [CBITS-1:0] prev;
  logic [CBITS-1:0] prev_inc;
  logic [1:0]       state, state_nx;
  logic [7:0]       run, run_nx;
  logic             active, good, rpt, bad;

  // bin[i] is the XOR of all Gray bits at or above position i.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < CBITS; i++) begin
      bin_c[i] = ^(g1 >> i);
    end
  end

  assign prev_inc = prev + CBITS'(1);
  assign active   = v1 && (state != S_IDLE);
  assign good     = active && (bin_c == prev_inc);
  assign rpt      = active && (bin_c == prev);
  assign bad      = active && !good && !rpt;

  always_comb begin
    state_nx = state;
    run_nx   = run;
    if (v1) begin
      case (state)
        S_IDLE: begin
          state_nx = S_ACQ;
          run_nx   = 8'd0;
        end
        S_ACQ: begin
          if (good) begin
            run_nx = run + 8'd1;
            if (run_nx == LOCK_N8) state_nx = S_LOCK;
          end else if (bad) begin
            run_nx = 8'd0;
          end
        end
        S_LOCK: begin
          if (bad) begin
            state_nx = S_ACQ;
            run_nx   = 8'd0;
          end
        end
        default: begin
          state_nx = S_IDLE;
          run_nx   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1         <= '0;
      v1         <= 1'b0;
      prev       <= '0;
      bin_out    <= '0;
      bin_vld    <= 1'b0;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
      zero_seen  <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= '0;
      state      <= S_IDLE;
      run        <= 8'd0;
    end else begin
      v1 <= gray_vld;
      if (gray_vld) g1 <= gray_in;
      bin_vld <= v1;
      // prev follows every decoded word, so a bad step re-syncs the checker.
      if (v1) begin
        bin_out <= bin_c;
        prev    <= bin_c;
      end
      step_err   <= bad;
      wrap_pulse <= good && (prev == ALL_ONES);
      zero_seen  <= v1 && (bin_c == '0);
      locked     <= (state_nx == S_LOCK);
      if (bad && (err_cnt != EC_MAX)) err_cnt <= err_cnt + ECBITS'(1);
      state <= state_nx;
      run   <= run_nx;
    end
  end

  assign state_dbg = state;
  assign run_dbg   = run;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder (CBITS=4, LOCK_N=4, ECBITS=3) with a scoreboard queue
// filled by the driver and drained by a monitor on every bin_vld.
`timescale 1ns/1ps
module tb_gray_rx_decoder;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       gray_vld;
  logic [3:0] bin_out;
  logic       bin_vld, step_err, wrap_pulse, zero_seen, locked;
  logic [2:0] err_cnt;
  logic [1:0] state_dbg;
  logic [7:0] run_dbg;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  gray_rx_decoder #(.CBITS(4), .LOCK_N(4), .ECBITS(3)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .gray_vld(gray_vld),
    .bin_out(bin_out), .bin_vld(bin_vld), .step_err(step_err),
    .wrap_pulse(wrap_pulse), .zero_seen(zero_seen), .locked(locked),
    .err_cnt(err_cnt), .state_dbg(state_dbg), .run_dbg(run_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {bin, step_err, wrap, zero, locked, err_cnt, state, run}
  function automatic logic [W-1:0] mk(input logic [3:0] b, input logic se, input logic wr,
                                      input logic zs, input logic lk, input logic [2:0] ec,
                                      input logic [1:0] st, input logic [7:0] rn);
    return {b, se, wr, zs, lk, ec, st, rn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".bin_out"},    32'(bin_out),    32'd0);
    check({tag, ".bin_vld"},    32'(bin_vld),    32'd0);
    check({tag, ".step_err"},   32'(step_err),   32'd0);
    check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    check({tag, ".zero_seen"},  32'(zero_seen),  32'd0);
    check({tag, ".locked"},     32'(locked),     32'd0);
    check({tag, ".err_cnt"},    32'(err_cnt),    32'd0);
    check({tag, ".state"},      32'(state_dbg),  32'd0);
    check({tag, ".run"},        32'(run_dbg),    32'd0);
  endtask

  // driver tasks
  task automatic send(input logic [3:0] g, input logic [W-1:0] e);
    @(negedge clk);
    gray_in  = g;
    gray_vld = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic send_np(input logic [3:0] g);
    @(negedge clk);
    gray_in  = g;
    gray_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gray_vld = 1'b0;
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bin_vld) begin
        act = {bin_out, step_err, wrap_pulse, zero_seen, locked, err_cnt, state_dbg, run_dbg};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bin_vld: got bin=%0h with no word expected", bin_out);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL word: got bin=%0h se=%0b wr=%0b zs=%0b lk=%0b ec=%0d st=%0d run=%0d expected bin=%0h se=%0b wr=%0b zs=%0b lk=%0b ec=%0d st=%0d run=%0d",
                     act[20:17], act[16], act[15], act[14], act[13], act[12:10], act[9:8], act[7:0],
                     e[20:17], e[16], e[15], e[14], e[13], e[12:10], e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] wg[11];
    wg = '{4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    rst = 1'b1; gray_vld = 1'b0; gray_in = 4'h0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // decode + latency + lock acquisition: gray 0,1,3,2,6 -> bin 0..4
    send(4'h0, mk(4'd0, 0, 0, 1, 0, 3'd0, 2'd1, 8'd0));
    send(4'h1, mk(4'd1, 0, 0, 0, 0, 3'd0, 2'd1, 8'd1));
    send(4'h3, mk(4'd2, 0, 0, 0, 0, 3'd0, 2'd1, 8'd2));
    send(4'h2, mk(4'd3, 0, 0, 0, 0, 3'd0, 2'd1, 8'd3));
    send(4'h6, mk(4'd4, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    idle(2);

    // locked stream through the wrap: bin 5..15 then 0
    for (int i = 0; i < 11; i++)
      send(wg[i], mk(4'(i + 5), 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'h0, mk(4'd0, 0, 1, 1, 1, 3'd0, 2'd2, 8'd4));
    idle(2);

    // bin 1..5 locked, then jump to 10 (bad), then 11 (good)
    send(4'h1, mk(4'd1, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'h3, mk(4'd2, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'h2, mk(4'd3, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'h6, mk(4'd4, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'h7, mk(4'd5, 0, 0, 0, 1, 3'd0, 2'd2, 8'd4));
    send(4'hF, mk(4'd10, 1, 0, 0, 0, 3'd1, 2'd1, 8'd0));
    send(4'hE, mk(4'd11, 0, 0, 0, 0, 3'd1, 2'd1, 8'd1));
    idle(1);

    // resync to 2, then 3,3,4 with gaps
    send(4'h3, mk(4'd2, 1, 0, 0, 0, 3'd2, 2'd1, 8'd0));
    idle(2);
    send(4'h2, mk(4'd3, 0, 0, 0, 0, 3'd2, 2'd1, 8'd1));
    idle(2);
    send(4'h2, mk(4'd3, 0, 0, 0, 0, 3'd2, 2'd1, 8'd1));
    idle(1);
    send(4'h6, mk(4'd4, 0, 0, 0, 0, 3'd2, 2'd1, 8'd2));
    idle(2);

    // nine bad words alternating bin 0 / 8: err_cnt 3..7 then saturates
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0)
        send(4'h0, mk(4'd0, 1, 0, 1, 0, (i + 3 > 7) ? 3'd7 : 3'(i + 3), 2'd1, 8'd0));
      else
        send(4'hC, mk(4'd8, 1, 0, 0, 0, (i + 3 > 7) ? 3'd7 : 3'(i + 3), 2'd1, 8'd0));
    end
    idle(4);

    // reset mid-stream: two words in flight are dropped
    send(4'h1, mk(4'd1, 0, 0, 0, 0, 3'd7, 2'd1, 8'd1));
    send_np(4'h3);
    send_np(4'h2);
    #1 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    gray_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);

    // first word after reset takes IDLE handling, no error check
    send(4'h5, mk(4'd6, 0, 0, 0, 0, 3'd0, 2'd1, 8'd0));
    send(4'h4, mk(4'd7, 0, 0, 0, 0, 3'd0, 2'd1, 8'd1));
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
